// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port, synchronous-read data memory between
// the core load/store path and a DMA/loader port. Writes complete in the
// grant cycle; read data returns the cycle after the grant. The core is
// stalled while it has lost arbitration or is waiting on a load.
//
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority, where the
// core always wins when it is eligible. Leave it undefined for round-robin.

module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_c_req,
  input  logic              i_c_we,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [DATA_W-1:0] i_c_wdata,
  output logic              o_c_gnt,
  output logic              o_c_rvalid,
  output logic [DATA_W-1:0] o_c_rdata,
  output logic              o_stall,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic {C_IDLE, C_WAIT} core_state_t;
  typedef enum logic [1:0] {RD_NONE, RD_CORE, RD_DMA} rd_owner_t;

  core_state_t core_state;
  rd_owner_t   rd_owner;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic        last_owner_dma;
`endif

  logic core_elig;
  logic c_gnt;
  logic d_gnt;

  // Pick at most one winner per cycle; everything is forced off while reset is held
  always_comb begin
    core_elig = i_c_req & (core_state == C_IDLE);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    c_gnt = i_rst_n & core_elig;
`else
    c_gnt = i_rst_n & core_elig & (~i_d_req | last_owner_dma);
`endif
    d_gnt = i_rst_n & i_d_req & ~c_gnt;
  end

  // Steer the granted port onto the memory bus, all zero when nobody is granted
  always_comb begin
    o_mem_en    = c_gnt | d_gnt;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (c_gnt) begin
      o_mem_we    = i_c_we;
      o_mem_addr  = i_c_addr;
      o_mem_wdata = i_c_wdata;
    end else if (d_gnt) begin
      o_mem_we    = i_d_we;
      o_mem_addr  = i_d_addr;
      o_mem_wdata = i_d_wdata;
    end
  end

  assign o_c_gnt    = c_gnt;
  assign o_d_gnt    = d_gnt;
  assign o_stall    = i_rst_n & i_c_req & (core_state == C_IDLE) & ~(c_gnt & i_c_we);
  assign o_c_rvalid = (rd_owner == RD_CORE);
  assign o_d_rvalid = (rd_owner == RD_DMA);
  assign o_c_rdata  = o_c_rvalid ? i_mem_rdata : '0;
  assign o_d_rdata  = o_d_rvalid ? i_mem_rdata : '0;

  // Track the core load wait, the owner of the returning read and the last winner
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      core_state     <= C_IDLE;
      rd_owner       <= RD_NONE;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_owner_dma <= 1'b1;
`endif
    end else begin
      case (core_state)
        C_IDLE:  core_state <= (c_gnt && !i_c_we) ? C_WAIT : C_IDLE;
        C_WAIT:  core_state <= C_IDLE;
        default: core_state <= C_IDLE;
      endcase

      if (c_gnt && !i_c_we)      rd_owner <= RD_CORE;
      else if (d_gnt && !i_d_we) rd_owner <= RD_DMA;
      else                       rd_owner <= RD_NONE;

`ifndef DMEM_ARB_FIXED_PRIO_EN
      if (c_gnt)      last_owner_dma <= 1'b0;
      else if (d_gnt) last_owner_dma <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter. Directed scenarios from
// the block's usage notes are followed by randomized traffic. A reference model
// predicts grants, stall and bus values each cycle and queues expected read
// returns; a separate monitor matches them against the DUT's rvalid outputs.

module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_rvalid, stall, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] phys_mem   [0:255];
  logic [31:0] shadow_mem [0:255];

  typedef struct {
    logic        is_dma;
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  rd_exp_t exp_q[$];

  int   n_vec;
  int   n_err;
  int   cyc;
  logic m_wait;
  logic m_last_dma;

  dmem_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_c_req     (c_req),
    .i_c_we      (c_we),
    .i_c_addr    (c_addr),
    .i_c_wdata   (c_wdata),
    .o_c_gnt     (c_gnt),
    .o_c_rvalid  (c_rvalid),
    .o_c_rdata   (c_rdata),
    .o_stall     (stall),
    .i_d_req     (d_req),
    .i_d_we      (d_we),
    .i_d_addr    (d_addr),
    .i_d_wdata   (d_wdata),
    .o_d_gnt     (d_gnt),
    .o_d_rvalid  (d_rvalid),
    .o_d_rdata   (d_rdata),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  // Free-running 10 ns clock; stimulus lands on the falling edge
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memory driven by the DUT's bus
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) phys_mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= phys_mem[mem_addr[7:0]];
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // One cycle: drive inputs, predict the response from the arbitration rules, check it
  task automatic apply_stimulus(
    input  logic        rst,
    input  logic        creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwdata,
    input  logic        dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata,
    output logic        cg,
    output logic        dg
  );
    logic        stall_e, we_e;
    logic [31:0] a_e, w_e;
    logic        core_ok;
    rd_exp_t     e;
    @(negedge clk);
    cyc++;
    rst_n   = rst;
    c_req   = creq;  c_we = cwe;  c_addr = caddr;  c_wdata = cwdata;
    d_req   = dreq;  d_we = dwe;  d_addr = daddr;  d_wdata = dwdata;
    cg      = 1'b0;
    dg      = 1'b0;
    stall_e = 1'b0;
    if (!rst) begin
      m_wait     = 1'b0;
      m_last_dma = 1'b1;
      exp_q.delete();
    end else begin
      core_ok = creq && !m_wait;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      cg = core_ok;
`else
      cg = core_ok && (!dreq || m_last_dma);
`endif
      dg      = dreq && !cg;
      stall_e = creq && !m_wait && !(cg && cwe);
    end
    we_e = cg ? cwe : (dg ? dwe : 1'b0);
    a_e  = cg ? caddr : (dg ? daddr : 32'h0);
    w_e  = cg ? cwdata : (dg ? dwdata : 32'h0);
    if (cg || dg) begin
      if (!we_e) begin
        e.is_dma = dg;
        e.data   = shadow_mem[a_e[7:0]];
        e.due    = cyc + 1;
        exp_q.push_back(e);
      end else begin
        shadow_mem[a_e[7:0]] = w_e;
      end
      m_last_dma = dg;
    end
    m_wait = cg && !cwe;
    #1;
    check_output("c_gnt",     32'(c_gnt),  32'(cg));
    check_output("d_gnt",     32'(d_gnt),  32'(dg));
    check_output("stall",     32'(stall),  32'(stall_e));
    check_output("mem_en",    32'(mem_en), 32'(cg || dg));
    check_output("mem_we",    32'(mem_we), 32'(we_e));
    check_output("mem_addr",  mem_addr,    a_e);
    check_output("mem_wdata", mem_wdata,   w_e);
  endtask

  // Monitor: pair every rvalid with the oldest expected read return
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (c_rvalid || d_rvalid) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_rvalid", {30'h0, c_rvalid, d_rvalid}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check_output("rvalid_port",  {30'h0, c_rvalid, d_rvalid}, e.is_dma ? 32'h1 : 32'h2);
          check_output("rvalid_cycle", 32'(cyc), 32'(e.due));
          check_output("rdata", e.is_dma ? d_rdata : c_rdata, e.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check_output("rvalid_missing", 32'h0, 32'h1);
      end
      if (!c_rvalid) check_output("c_rdata_idle", c_rdata, 32'h0);
      if (!d_rvalid) check_output("d_rdata_idle", d_rdata, 32'h0);
    end
  end

  // Directed scenarios, then randomized traffic with hold-until-grant requesters
  initial begin
    logic        cg, dg;
    logic        c_pend, c_hold_wait, d_pend;
    logic        r_cwe, r_dwe;
    logic [31:0] r_caddr, r_cwdata, r_daddr, r_dwdata;
    n_vec = 0;  n_err = 0;  cyc = 0;
    m_wait = 1'b0;  m_last_dma = 1'b1;
    rst_n = 1'b0;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      phys_mem[i]   = $urandom;
      shadow_mem[i] = phys_mem[i];
    end
    phys_mem[8'h40]   = 32'hDEADBEEF;
    shadow_mem[8'h40] = 32'hDEADBEEF;

    // Reset held with requests active: everything must stay quiet
    apply_stimulus(0, 1, 0, 32'h4, 32'h0, 1, 1, 32'h5, 32'h55, cg, dg);
    check_output("rst_c_rvalid", 32'(c_rvalid), 32'h0);
    check_output("rst_d_rvalid", 32'(d_rvalid), 32'h0);
    apply_stimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, cg, dg);

    // Core load alone from 0x40
    apply_stimulus(1, 1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, cg, dg);
    apply_stimulus(1, 1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, cg, dg);
    check_output("tp_load_rvalid", 32'(c_rvalid), 32'h1);
    check_output("tp_load_rdata",  c_rdata, 32'hDEADBEEF);
    apply_stimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, cg, dg);

    // Core store alone
    apply_stimulus(1, 1, 1, 32'h10, 32'h1234, 0, 0, 32'h0, 32'h0, cg, dg);
    apply_stimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, cg, dg);

    // Continuous stores from both ports straight out of reset
    apply_stimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, cg, dg);
    for (int i = 0; i < 6; i++)
      apply_stimulus(1, 1, 1, 32'(20 + i), 32'(i), 1, 1, 32'(40 + i), 32'(100 + i), cg, dg);

    // Simultaneous loads: core first, DMA during the core wait cycle
    apply_stimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, cg, dg);
    apply_stimulus(1, 1, 0, 32'h8, 32'h0, 1, 0, 32'hC, 32'h0, cg, dg);
    apply_stimulus(1, 1, 0, 32'h8, 32'h0, 1, 0, 32'hC, 32'h0, cg, dg);
    apply_stimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, cg, dg);
    apply_stimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, cg, dg);

    // Reset lands in the cycle after a core read grant; no rvalid may escape
    apply_stimulus(1, 1, 0, 32'h30, 32'h0, 0, 0, 32'h0, 32'h0, cg, dg);
    apply_stimulus(0, 1, 0, 32'h30, 32'h0, 1, 1, 32'h31, 32'h9, cg, dg);
    check_output("midrd_c_rvalid", 32'(c_rvalid), 32'h0);
    apply_stimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, cg, dg);
    apply_stimulus(1, 1, 1, 32'h32, 32'h77, 1, 1, 32'h33, 32'h88, cg, dg);
    apply_stimulus(1, 0, 0, 32'h0, 32'h0, 1, 1, 32'h33, 32'h88, cg, dg);
    apply_stimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, cg, dg);

    // Randomized traffic
    c_pend = 0;  c_hold_wait = 0;  d_pend = 0;
    r_cwe = 0;  r_caddr = 0;  r_cwdata = 0;
    r_dwe = 0;  r_daddr = 0;  r_dwdata = 0;
    for (int i = 0; i < 3000; i++) begin
      logic rst_now;
      rst_now = ($urandom_range(0, 199) != 0);
      if (!c_hold_wait && !c_pend && $urandom_range(0, 9) < 6) begin
        r_cwe    = 1'($urandom_range(0, 1));
        r_caddr  = 32'($urandom_range(0, 255));
        r_cwdata = $urandom;
        c_pend   = 1;
      end
      if (!d_pend && $urandom_range(0, 9) < 5) begin
        r_dwe    = 1'($urandom_range(0, 1));
        r_daddr  = 32'($urandom_range(0, 255));
        r_dwdata = $urandom;
        d_pend   = 1;
      end
      apply_stimulus(rst_now, c_pend || c_hold_wait, r_cwe, r_caddr, r_cwdata,
                     d_pend, r_dwe, r_daddr, r_dwdata, cg, dg);
      if (!rst_now) begin
        c_hold_wait = 0;
      end else if (c_hold_wait) begin
        c_hold_wait = 0;
      end else if (cg) begin
        c_pend      = 0;
        c_hold_wait = !r_cwe;
      end
      if (dg) d_pend = 0;
    end

    apply_stimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, cg, dg);
    apply_stimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, cg, dg);
    #3;
    check_output("rd_queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
